// File: rtl/nat_conn_table_if.sv
// Request/response bundle between the packet parser and the connection table.
// The parser side drives the tuple request; the table side returns the index and status.
interface nat_conn_table_if #(
   parameter int HASH_LEN = 6
);
   logic [127:0]      tuple_data_i;
   logic              tuple_valid_i;
   logic [15:0]       conn_data_o;
   logic              conn_valid_o;
   logic              conn_full_o;
   logic [HASH_LEN:0] conn_count_o;
   logic              busy_o;

   modport master (
      output tuple_data_i,
      output tuple_valid_i,
      input  conn_data_o,
      input  conn_valid_o,
      input  conn_full_o,
      input  conn_count_o,
      input  busy_o
   );

   modport slave (
      input  tuple_data_i,
      input  tuple_valid_i,
      output conn_data_o,
      output conn_valid_o,
      output conn_full_o,
      output conn_count_o,
      output busy_o
   );
endinterface

// File: rtl/nat_conn_table.sv
// Connection table: XOR-fold hash of the 5-tuple key, linear probing over a register table.
// Optional hit/insert/full counters are enabled by defining NAT_CONN_STATS_EN.
module nat_conn_table #(
   parameter int HASH_LEN = 6,
   parameter int KEY_W    = 104
) (
   input  logic            clk,
   input  logic            reset,
   nat_conn_table_if.slave conn_if
`ifdef NAT_CONN_STATS_EN
   ,
   output logic [31:0]     stat_hit_o,
   output logic [31:0]     stat_insert_o,
   output logic [31:0]     stat_full_o
`endif
);

   localparam int DEPTH  = 1 << HASH_LEN;
   localparam int NCHUNK = (KEY_W + HASH_LEN - 1) / HASH_LEN;

   typedef logic [HASH_LEN-1:0] idx_t;
   typedef logic [HASH_LEN:0]   cnt_t;
   typedef enum logic [1:0] {IDLE, PROBE, RESP, WAIT_DROP} state_t;

   state_t           state_q, state_d;
   logic [KEY_W-1:0] key_q, key_d;
   idx_t             idx_q, idx_d;
   idx_t             probeCnt_q, probeCnt_d;
   idx_t             result_q, result_d;
   logic             full_q, full_d;
   cnt_t             count_q, count_d;
   logic [15:0]      connData_q, connData_d;
   logic             connValid_q, connValid_d;
   logic             connFull_q, connFull_d;
   logic             tableWr;

   logic [DEPTH-1:0] valid_q;
   logic [KEY_W-1:0] keys_q [DEPTH];

   logic [NCHUNK*HASH_LEN-1:0] keyPad;
   idx_t             hashIdx;
   logic             entryValid;
   logic             entryMatch;
   logic             unused_hi;

   assign unused_hi = ^conn_if.tuple_data_i[127:KEY_W];

   // Fold the key into HASH_LEN-bit chunks; the top chunk is zero-padded
   always_comb begin
      keyPad = '0;
      keyPad[KEY_W-1:0] = conn_if.tuple_data_i[KEY_W-1:0];
      hashIdx = '0;
      for (int i = 0; i < NCHUNK; i++) begin
         hashIdx = hashIdx ^ keyPad[i*HASH_LEN +: HASH_LEN];
      end
   end

   assign entryValid = valid_q[idx_q];
   assign entryMatch = (keys_q[idx_q] == key_q);

   always_comb begin
      state_d     = state_q;
      key_d       = key_q;
      idx_d       = idx_q;
      probeCnt_d  = probeCnt_q;
      result_d    = result_q;
      full_d      = full_q;
      count_d     = count_q;
      connData_d  = connData_q;
      connValid_d = 1'b0;
      connFull_d  = 1'b0;
      tableWr     = 1'b0;
      case (state_q)
         IDLE: begin
            if (conn_if.tuple_valid_i) begin
               key_d      = conn_if.tuple_data_i[KEY_W-1:0];
               idx_d      = hashIdx;
               probeCnt_d = '0;
               full_d     = 1'b0;
               state_d    = PROBE;
            end
         end
         PROBE: begin
            if (entryValid && entryMatch) begin
               result_d = idx_q;
               state_d  = RESP;
            end else if (!entryValid) begin
               tableWr  = 1'b1;
               count_d  = count_q + cnt_t'(1);
               result_d = idx_q;
               state_d  = RESP;
            end else if (probeCnt_q == '1) begin
               result_d = '0;
               full_d   = 1'b1;
               state_d  = RESP;
            end else begin
               idx_d      = idx_q + idx_t'(1);
               probeCnt_d = probeCnt_q + idx_t'(1);
            end
         end
         // The result strobe is registered, so it appears in the cycle after RESP
         RESP: begin
            connValid_d = 1'b1;
            connData_d  = 16'(result_q);
            connFull_d  = full_q;
            state_d     = WAIT_DROP;
         end
         WAIT_DROP: begin
            if (!conn_if.tuple_valid_i) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= IDLE;
         key_q       <= '0;
         idx_q       <= '0;
         probeCnt_q  <= '0;
         result_q    <= '0;
         full_q      <= 1'b0;
         count_q     <= '0;
         connData_q  <= '0;
         connValid_q <= 1'b0;
         connFull_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         key_q       <= key_d;
         idx_q       <= idx_d;
         probeCnt_q  <= probeCnt_d;
         result_q    <= result_d;
         full_q      <= full_d;
         count_q     <= count_d;
         connData_q  <= connData_d;
         connValid_q <= connValid_d;
         connFull_q  <= connFull_d;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         valid_q <= '0;
      end else if (tableWr) begin
         valid_q[idx_q] <= 1'b1;
      end
   end

   // Key storage is qualified by valid_q, so it needs no reset
   always_ff @(posedge clk) begin
      if (tableWr) begin
         keys_q[idx_q] <= key_q;
      end
   end

   assign conn_if.conn_data_o  = connData_q;
   assign conn_if.conn_valid_o = connValid_q;
   assign conn_if.conn_full_o  = connFull_q;
   assign conn_if.conn_count_o = count_q;
   assign conn_if.busy_o       = (state_q != IDLE);

`ifdef NAT_CONN_STATS_EN
   logic [31:0] statHit_q, statIns_q, statFull_q;
   logic        inserted_q;

   // A lookup that neither inserted nor hit the full condition was a hit
   always_ff @(posedge clk) begin
      if (reset) begin
         statHit_q  <= '0;
         statIns_q  <= '0;
         statFull_q <= '0;
         inserted_q <= 1'b0;
      end else begin
         if (tableWr) begin
            inserted_q <= 1'b1;
         end
         if (state_q == RESP) begin
            inserted_q <= 1'b0;
            if (full_q) begin
               statFull_q <= statFull_q + 32'd1;
            end else if (inserted_q) begin
               statIns_q <= statIns_q + 32'd1;
            end else begin
               statHit_q <= statHit_q + 32'd1;
            end
         end
      end
   end

   assign stat_hit_o    = statHit_q;
   assign stat_insert_o = statIns_q;
   assign stat_full_o   = statFull_q;
`endif

endmodule

// File: tb/tb_nat_conn_table.sv
// Bench for nat_conn_table: one 64-entry and one 4-entry instance against a probing model.
// Stats outputs are checked when NAT_CONN_STATS_EN is defined.
module tb_nat_conn_table;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic         rst6, rst2;
   logic [127:0] td;
   logic         tv;
   logic         useSmall;

   nat_conn_table_if #(.HASH_LEN(6)) if6 ();
   nat_conn_table_if #(.HASH_LEN(2)) if2 ();

   assign if6.tuple_data_i  = td;
   assign if2.tuple_data_i  = td;
   assign if6.tuple_valid_i = tv & ~useSmall;
   assign if2.tuple_valid_i = tv & useSmall;

`ifdef NAT_CONN_STATS_EN
   logic [31:0] sh6, si6, sf6, sh2, si2, sf2;
`endif

   nat_conn_table #(.HASH_LEN(6)) dut6 (
      .clk(clk),
      .reset(rst6),
      .conn_if(if6)
`ifdef NAT_CONN_STATS_EN
      ,
      .stat_hit_o(sh6),
      .stat_insert_o(si6),
      .stat_full_o(sf6)
`endif
   );

   nat_conn_table #(.HASH_LEN(2)) dut2 (
      .clk(clk),
      .reset(rst2),
      .conn_if(if2)
`ifdef NAT_CONN_STATS_EN
      ,
      .stat_hit_o(sh2),
      .stat_insert_o(si2),
      .stat_full_o(sf2)
`endif
   );

   logic        cv, cf, cbusy;
   logic [15:0] cdata;
   logic [31:0] ccount;
   assign cv     = useSmall ? if2.conn_valid_o : if6.conn_valid_o;
   assign cf     = useSmall ? if2.conn_full_o  : if6.conn_full_o;
   assign cbusy  = useSmall ? if2.busy_o       : if6.busy_o;
   assign cdata  = useSmall ? if2.conn_data_o  : if6.conn_data_o;
   assign ccount = useSmall ? 32'(if2.conn_count_o) : 32'(if6.conn_count_o);

   int errors = 0;
   int checks = 0;

   // Reference table: index 0 models the 64-entry instance, index 1 the 4-entry one
   logic [103:0] mKey [2][64];
   bit           mVal [2][64];
   int           mCount [2];
   int           mHit [2];
   int           mIns [2];
   int           mFull [2];
   int           hlen [2] = '{6, 2};

   // Key bit b lands on hash bit (b mod HASH_LEN)
   function automatic int refHash(input logic [103:0] k, input int h);
      int r = 0;
      for (int b = 0; b < 104; b++) begin
         if (k[b]) r = r ^ (1 << (b % h));
      end
      return r;
   endfunction

   task automatic modelReset(input int s);
      for (int i = 0; i < 64; i++) mVal[s][i] = 1'b0;
      mCount[s] = 0;
      mHit[s]   = 0;
      mIns[s]   = 0;
      mFull[s]  = 0;
   endtask

   task automatic modelLookup(input int s, input logic [103:0] k,
                              output int idx, output bit full, output int p);
      int  d    = 1 << hlen[s];
      int  h    = refHash(k, hlen[s]);
      bit  done = 1'b0;
      idx  = 0;
      full = 1'b1;
      p    = d - 1;
      for (int i = 0; i < d; i++) begin
         int j = (h + i) % d;
         if (!done && mVal[s][j] && mKey[s][j] == k) begin
            idx = j; full = 1'b0; p = i; done = 1'b1;
            mHit[s]++;
         end else if (!done && !mVal[s][j]) begin
            mVal[s][j] = 1'b1;
            mKey[s][j] = k;
            mCount[s]++;
            idx = j; full = 1'b0; p = i; done = 1'b1;
            mIns[s]++;
         end
      end
      if (!done) mFull[s]++;
   endtask

   // Drives one request and measures the response; the caller does the comparisons
   task automatic applyStimulus(input int s, input logic [127:0] key, input int hold,
                                input bit dropEarly, output bit got, output int lat,
                                output logic [15:0] data, output logic full,
                                output int count, output int extra);
      useSmall = (s == 1);
      @(negedge clk);
      td = key;
      tv = 1'b1;
      @(posedge clk);
      if (dropEarly) begin
         #1;
         tv = 1'b0;
      end
      got   = 1'b0;
      lat   = 0;
      data  = 'x;
      full  = 1'bx;
      count = -1;
      for (int n = 1; n <= 80 && !got; n++) begin
         @(posedge clk);
         #1;
         if (cv === 1'b1) begin
            got   = 1'b1;
            lat   = n;
            data  = cdata;
            full  = cf;
            count = int'(ccount);
         end
      end
      extra = 0;
      for (int n = 0; n < hold; n++) begin
         @(posedge clk);
         #1;
         if (cv !== 1'b0) extra++;
      end
      tv = 1'b0;
      @(posedge clk);
      #1;
      if (cv !== 1'b0) extra++;
   endtask

   task automatic test_reset();
      tv = 1'b0; td = '0; useSmall = 1'b0;
      rst6 = 1'b1; rst2 = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      for (int s = 0; s < 2; s++) begin
         useSmall = (s == 1);
         #1;
         checks++; if (cbusy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy s=%0d actual=%b required=0", s, cbusy); end
         checks++; if (cv !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid s=%0d actual=%b required=0", s, cv); end
         checks++; if (cf !== 1'b0) begin errors++; $display("[TB] FAIL reset_full s=%0d actual=%b required=0", s, cf); end
         checks++; if (cdata !== 16'd0) begin errors++; $display("[TB] FAIL reset_data s=%0d actual=%0d required=0", s, cdata); end
         checks++; if (ccount !== 32'd0) begin errors++; $display("[TB] FAIL reset_count s=%0d actual=%0d required=0", s, ccount); end
      end
      @(negedge clk);
      rst6 = 1'b0; rst2 = 1'b0;
      modelReset(0);
      modelReset(1);
   endtask

   // One lookup against the model, with all response fields compared
   task automatic test_lookup(input string name, input int s, input logic [127:0] key,
                              input int hold, input bit dropEarly);
      bit got; int lat; logic [15:0] data; logic full; int count; int extra;
      int eIdx; bit eFull; int eP;
      modelLookup(s, key[103:0], eIdx, eFull, eP);
      applyStimulus(s, key, hold, dropEarly, got, lat, data, full, count, extra);
      checks++; if (got !== 1'b1) begin errors++; $display("[TB] FAIL %s_timeout actual=no_response required=response", name); end
      checks++; if (lat !== 2 + eP) begin errors++; $display("[TB] FAIL %s_latency actual=%0d required=%0d", name, lat, 2 + eP); end
      checks++; if (data !== 16'(eIdx)) begin errors++; $display("[TB] FAIL %s_data actual=%0d required=%0d", name, data, eIdx); end
      checks++; if (full !== eFull) begin errors++; $display("[TB] FAIL %s_full actual=%b required=%b", name, full, eFull); end
      checks++; if (count !== mCount[s]) begin errors++; $display("[TB] FAIL %s_count actual=%0d required=%0d", name, count, mCount[s]); end
      checks++; if (extra !== 0) begin errors++; $display("[TB] FAIL %s_extra_pulses actual=%0d required=0", name, extra); end
   endtask

   task automatic test_first_insert();
      test_lookup("first_insert", 0, 128'h1, 3, 1'b0);
      checks++; if (mCount[0] != 1 || refHash(104'h1, 6) != 1) begin errors++; $display("[TB] FAIL first_insert_model actual=%0d required=1", mCount[0]); end
   endtask

   task automatic test_hit();
      test_lookup("hit", 0, 128'h1, 2, 1'b0);
`ifdef NAT_CONN_STATS_EN
      checks++; if (sh6 !== 32'd1) begin errors++; $display("[TB] FAIL hit_stat actual=%0d required=1", sh6); end
`endif
   endtask

   task automatic test_collision();
      test_lookup("collision_insert", 0, 128'h40, 2, 1'b0);
      test_lookup("collision_hit", 0, 128'h40, 2, 1'b0);
   endtask

   task automatic test_random();
      logic [103:0] pool [10];
      for (int i = 0; i < 10; i++) begin
         logic [31:0] a, b, c, d;
         a = $urandom; b = $urandom; c = $urandom; d = $urandom;
         if (i < 5) pool[i] = 104'($urandom_range(0, 255));
         else       pool[i] = {a[7:0], b, c, d};
      end
      for (int n = 0; n < 30; n++) begin
         logic [31:0] hi;
         int k;
         hi = $urandom;
         k  = $urandom_range(0, 9);
         test_lookup("random", 0, {hi[23:0], pool[k]}, $urandom_range(0, 2), ($urandom_range(0, 3) == 0));
      end
`ifdef NAT_CONN_STATS_EN
      checks++; if (sh6 !== 32'(mHit[0])) begin errors++; $display("[TB] FAIL random_stat_hit actual=%0d required=%0d", sh6, mHit[0]); end
      checks++; if (si6 !== 32'(mIns[0])) begin errors++; $display("[TB] FAIL random_stat_insert actual=%0d required=%0d", si6, mIns[0]); end
      checks++; if (sf6 !== 32'(mFull[0])) begin errors++; $display("[TB] FAIL random_stat_full actual=%0d required=%0d", sf6, mFull[0]); end
`endif
   endtask

   task automatic test_back_to_back();
      logic [31:0] r;
      r = $urandom;
      test_lookup("hold_high", 0, {96'h0, r | 32'h1000}, 10, 1'b0);
      test_lookup("after_drop", 0, {96'h0, r | 32'h2000}, 0, 1'b0);
   endtask

   task automatic test_wrap_full();
      test_lookup("wrap_first", 1, 128'h3, 0, 1'b0);
      test_lookup("wrap_second", 1, 128'hC, 0, 1'b0);
      test_lookup("fill_a", 1, 128'h1, 0, 1'b0);
      test_lookup("fill_b", 1, 128'h2, 0, 1'b0);
      test_lookup("full_miss", 1, 128'h5, 0, 1'b0);
      checks++; if (mFull[1] != 1 || mCount[1] != 4) begin errors++; $display("[TB] FAIL full_model actual=%0d required=4", mCount[1]); end
`ifdef NAT_CONN_STATS_EN
      checks++; if (sf2 !== 32'd1) begin errors++; $display("[TB] FAIL full_stat actual=%0d required=1", sf2); end
      checks++; if (si2 !== 32'd4) begin errors++; $display("[TB] FAIL full_stat_insert actual=%0d required=4", si2); end
`endif
   endtask

   task automatic test_reset_mid_probe();
      int pulses = 0;
      useSmall = 1'b1;
      @(negedge clk);
      td = 128'h6;
      tv = 1'b1;
      @(posedge clk);
      @(posedge clk);
      @(negedge clk);
      rst2 = 1'b1;
      tv   = 1'b0;
      @(posedge clk);
      #1;
      checks++; if (cbusy !== 1'b0) begin errors++; $display("[TB] FAIL midreset_busy actual=%b required=0", cbusy); end
      checks++; if (ccount !== 32'd0) begin errors++; $display("[TB] FAIL midreset_count actual=%0d required=0", ccount); end
      if (cv !== 1'b0) pulses++;
      @(negedge clk);
      rst2 = 1'b0;
      modelReset(1);
      for (int n = 0; n < 10; n++) begin
         @(posedge clk);
         #1;
         if (cv !== 1'b0) pulses++;
      end
      checks++; if (pulses !== 0) begin errors++; $display("[TB] FAIL midreset_pulses actual=%0d required=0", pulses); end
      test_lookup("reinsert", 1, 128'h3, 0, 1'b0);
   endtask

   initial begin
      test_reset();
      test_first_insert();
      test_hit();
      test_collision();
      test_random();
      test_back_to_back();
      test_wrap_full();
      test_reset_mid_probe();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/nat_conn_table.md
Name: nat_conn_table

Overview:
- Connection-table lookup stage that consumes the 5-tuple emitted by the packet parser/rewriter and returns the connection index it writes into the TCP port field.
- Hashes the 104-bit tuple key and resolves collisions by linear probing over a register-based table.
- Returns the existing index on a hit; on a miss, claims the first empty slot.
- Sits directly beside the parser: the parser stalls its AXI-Stream path while this block searches.

Parameters:
- HASH_LEN, 6, table index width; table depth = 2^HASH_LEN; legal range 1..16.
- KEY_W, 104, key width taken from tuple_data_i[KEY_W-1:0] ({src_ip, dst_ip, src_port, dst_port, protocol}).

Ports:
- clk  input  1  single clock, all logic on posedge.
- reset  input  1  synchronous, active-high reset.
- tuple_data_i  input  128  tuple from parser; bits [127:104] ignored.
- tuple_valid_i  input  1  level request; parser holds it high until it samples conn_valid_o, then drops it.
- conn_data_o  output  16  result index, zero-extended from HASH_LEN bits.
- conn_valid_o  output  1  one-cycle result strobe.
- conn_full_o  output  1  one-cycle strobe together with conn_valid_o when a miss found no free slot.
- conn_count_o  output  HASH_LEN+1  number of occupied entries.
- busy_o  output  1  high in any state other than IDLE.

Behaviour:
- Table: 2^HASH_LEN entries of {valid, key[KEY_W-1:0]}; registers, no RAM; entries are never removed except by reset.
- Hash, combinational on tuple_data_i: XOR-fold of key[KEY_W-1:0] into HASH_LEN-bit chunks, chunk0 = key[HASH_LEN-1:0]; last chunk zero-padded.
- Example, HASH_LEN=6: key 0x1 -> 1; key 0x40 -> 1.
- Reset (sync, any state, including mid-probe):
  - state = IDLE; all valid bits = 0; conn_count_o = 0.
  - conn_valid_o = 0; conn_full_o = 0; conn_data_o = 0; busy_o = 0.
- FSM states: IDLE, PROBE, RESP, WAIT_DROP.
- IDLE:
  - On an edge with tuple_valid_i=1: latch key, idx = hash, probe_cnt = 0; go to PROBE.
- PROBE: one entry examined per cycle at idx.
  - entry valid and key match -> result = idx, hit; go to RESP.
  - entry invalid -> write {1, key} at idx, conn_count_o += 1, result = idx; go to RESP.
  - otherwise, if probe_cnt == 2^HASH_LEN-1 -> full: result = 0, set full flag; go to RESP.
  - otherwise -> idx = idx+1 (wraps modulo 2^HASH_LEN), probe_cnt += 1; stay in PROBE.
- RESP: conn_valid_o = 1 and conn_data_o = result for exactly this one cycle; conn_full_o = full flag; go to WAIT_DROP.
- WAIT_DROP: stay until tuple_valid_i is sampled 0, then go to IDLE.
  - tuple_valid_i remaining high here never starts a second lookup.
- Latency: conn_valid_o is high in the cycle starting at edge E0+2+p.
  - E0 = the accept edge; p = extra probes beyond the first.
  - First-probe result: conn_valid_o high 2 cycles after accept.
  - Worst case p = 2^HASH_LEN-1.
- conn_data_o holds its last value until the next RESP.
- conn_count_o saturates at 2^HASH_LEN; an insert is impossible when full.
- tuple_valid_i dropping mid-probe: the search still completes and still inserts/responds.

Optional Feature:
- Macro: NAT_CONN_STATS_EN.
- When defined, adds three 32-bit outputs, each incremented in the RESP cycle of its outcome, cleared by reset, wrapping at 2^32:
  - stat_hit_o: lookups that hit.
  - stat_insert_o: lookups that inserted.
  - stat_full_o: lookups that failed because the table was full.
- When undefined, these ports and counters do not exist; all other behaviour is identical.

Test Plan (HASH_LEN=6 unless stated):
- Reset, then key 0x1 held until response -> conn_valid_o high 2 cycles after accept; conn_data_o=1, conn_full_o=0, conn_count_o=1; one pulse only.
- Key 0x1 again -> hit: conn_data_o=1, 2-cycle latency, conn_count_o stays 1 (with stats: stat_hit_o=1).
- Collision: key 0x40 (hash 1) -> probes idx 1 then idx 2; conn_data_o=2, latency 3 cycles, conn_count_o=2; repeat key 0x40 -> hit at 2.
- Wrap: with HASH_LEN=2, insert keys hashing to 3 twice -> second gets idx 0; fill all 4 entries, then a 5th new key -> after 4 probes conn_full_o=1, conn_data_o=0, conn_count_o=4.
- Hold tuple_valid_i high 10 cycles after the response -> no second conn_valid_o; drop it for one cycle, raise it with a new key -> new lookup starts.
- Assert reset during PROBE -> next cycle busy_o=0, conn_count_o=0, conn_valid_o never pulses; a prior key is re-inserted as new after reset.
